// File: rtl/core_mac_pkg.sv
// Shared constants for core_mac: opcode classes, unary codes, register map and FSM states.
package core_mac_pkg;

   localparam logic [1:0] CLS_LOAD  = 2'b00;
   localparam logic [1:0] CLS_ALU   = 2'b01;
   localparam logic [1:0] CLS_UNARY = 2'b10;
   localparam logic [1:0] CLS_STORE = 2'b11;

   localparam logic [2:0] UN_CLEAR = 3'b000;
   localparam logic [2:0] UN_NEG   = 3'b001;
   localparam logic [2:0] UN_ASR   = 3'b010;
   localparam logic [2:0] UN_SHL   = 3'b011;
   localparam logic [2:0] UN_ABS   = 3'b100;

   localparam logic [4:0] REG_ZERO        = 5'd14;
   localparam logic [4:0] REG_CORE_ID     = 5'd15;
   localparam logic [4:0] REG_GLOBAL_BASE = 5'd16;

   typedef enum logic [1:0] {IDLE, MUL, WB} mac_state_e;

endpackage

// File: rtl/core_mac_seq_multiplier.sv
// Unsigned radix-2 shift-add multiplier; one partial product per cycle after start_i.
module seq_multiplier #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic           last_o,
   output logic [2*W-1:0] product_o
);

   localparam int CW = $clog2(W);

   logic [2*W-1:0] mcand_q;
   logic [W-1:0]   mplier_q;
   logic [2*W-1:0] prod_q;
   logic [CW-1:0]  cnt_q;
   logic           busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= (2*W)'(a_i);
         mplier_q <= b_i;
         prod_q   <= '0;
         cnt_q    <= CW'(W-1);
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         if (mplier_q[0]) prod_q <= prod_q + mcand_q;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         if (cnt_q == '0) busy_q <= 1'b0;
         else             cnt_q  <= cnt_q - 1'b1;
      end
   end

   // High during the cycle whose edge adds the final partial product.
   assign last_o    = busy_q && (cnt_q == '0);
   assign product_o = prod_q;

endmodule

// File: rtl/core_mac.sv
// Shader core with local/global register reads, wide signed accumulator and iterative signed MAC.
module core_mac
   import core_mac_pkg::*;
#(
   parameter int CORE_ID        = 0,
   parameter int BIT_WIDTH      = 8,
   parameter int NR_LOCAL_REGS  = 8,
   parameter int NR_GLOBAL_REGS = 9,
   parameter int ACC_WIDTH      = 2*BIT_WIDTH+4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [15:0]                         opcode,
   input  logic                                execute,
   input  logic [NR_GLOBAL_REGS*BIT_WIDTH-1:0] global_registers_in,
   output logic                                ready,
   output logic [ACC_WIDTH-1:0]                accu,
   output logic                                overflow
);

   // state | meaning
   // IDLE  | accepting opcodes; single-cycle ops retire here
   // MUL   | seq_multiplier running, execute ignored
   // WB    | signed product written or accumulated into accu

   localparam int BW = BIT_WIDTH;
   localparam int AW = ACC_WIDTH;
   localparam int LW = $clog2(NR_LOCAL_REGS);
   localparam logic [AW-1:0] SAT_MAX = AW'((1 << (BW-1)) - 1);
   localparam logic [AW-1:0] SAT_MIN = ~SAT_MAX;

   mac_state_e        state_q;
   logic [BW-1:0]     regs_q [NR_LOCAL_REGS];
   logic [AW-1:0]     accu_q;
   logic              ovf_q, ready_q, sign_q, mac_q, sub_q;

   logic [NR_LOCAL_REGS*BW-1:0] regs_flat;
   logic [BW-1:0]     op_a, op_b, abs_a, abs_b, wr_data;
   logic [AW-1:0]     a_ext, b_ext, alu_accu, p_ext, p_signed, wb_accu, st_v;
   logic [AW:0]       res, wb_res;
   logic              alu_ovf, wr_en, is_mul, acc_min, mul_last, start_mul, wb_ovf;
   logic [2*BW-1:0]   mul_prod;

   function automatic logic [BW-1:0] sel_reg(input logic [4:0] idx,
                                             input logic [NR_LOCAL_REGS*BW-1:0] loc,
                                             input logic [NR_GLOBAL_REGS*BW-1:0] glb);
      int i;
      i = int'(idx);
      sel_reg = '0;
      if (i < NR_LOCAL_REGS)              sel_reg = loc[i*BW +: BW];
      else if (i == int'(REG_ZERO))       sel_reg = '0;
      else if (i == int'(REG_CORE_ID))    sel_reg = BW'(CORE_ID);
      else if (i >= int'(REG_GLOBAL_BASE) && i < int'(REG_GLOBAL_BASE) + NR_GLOBAL_REGS)
         sel_reg = glb[(i - int'(REG_GLOBAL_BASE))*BW +: BW];
   endfunction

   // Returns {signed_overflow, result}.
   function automatic logic [AW:0] addsub(input logic [AW-1:0] x, input logic [AW-1:0] y,
                                          input logic sub);
      logic [AW-1:0] s;
      logic          o;
      s = sub ? x - y : x + y;
      o = ((x[AW-1] ^ y[AW-1]) == sub) && (s[AW-1] != x[AW-1]);
      return {o, s};
   endfunction

   always_comb begin
      for (int i = 0; i < NR_LOCAL_REGS; i++) regs_flat[i*BW +: BW] = regs_q[i];
   end

   assign op_a    = sel_reg(opcode[13:9], regs_flat, global_registers_in);
   assign op_b    = sel_reg({1'b0, opcode[8:5]}, regs_flat, global_registers_in);
   assign a_ext   = AW'($signed(op_a));
   assign b_ext   = AW'($signed(op_b));
   assign abs_a   = op_a[BW-1] ? -op_a : op_a;
   assign abs_b   = op_b[BW-1] ? -op_b : op_b;
   assign is_mul  = (opcode[15:14] == CLS_ALU) && opcode[1];
   assign acc_min = accu_q[AW-1] && (accu_q[AW-2:0] == '0);
   assign wr_en   = ((opcode[15:14] == CLS_LOAD) || ((opcode[15:14] == CLS_STORE) && opcode[8]))
                    && (int'(opcode[13:9]) < NR_LOCAL_REGS);
   assign start_mul = (state_q == IDLE) && execute && is_mul;

   always_comb begin
      alu_accu = accu_q;
      alu_ovf  = ovf_q;
      wr_data  = '0;
      res      = '0;
      st_v     = '0;
      case (opcode[15:14])
         CLS_LOAD: wr_data = BW'($signed(opcode[7:0]));
         CLS_ALU: begin
            if (!opcode[1]) begin
               res      = addsub(opcode[2] ? accu_q : a_ext, opcode[3] ? accu_q : b_ext, opcode[0]);
               alu_accu = res[AW-1:0];
               alu_ovf  = ovf_q | res[AW];
            end
         end
         CLS_UNARY: begin
            case (opcode[2:0])
               UN_CLEAR: begin
                  alu_accu = '0;
                  alu_ovf  = 1'b0;
               end
               UN_NEG: begin
                  alu_accu = -accu_q;
                  alu_ovf  = ovf_q | acc_min;
               end
               UN_ASR: alu_accu = $signed(accu_q) >>> opcode[6:3];
               UN_SHL: alu_accu = accu_q << opcode[6:3];
               UN_ABS: begin
                  alu_accu = accu_q[AW-1] ? -accu_q : accu_q;
                  alu_ovf  = ovf_q | acc_min;
               end
               default: alu_accu = accu_q;
            endcase
         end
         default: begin
            st_v    = $signed(accu_q) >>> opcode[7:4];
            wr_data = st_v[BW-1:0];
            if (opcode[3] && ($signed(st_v) > $signed(SAT_MAX))) begin
               wr_data = {1'b0, {(BW-1){1'b1}}};
               alu_ovf = ovf_q | opcode[8];
            end else if (opcode[3] && ($signed(st_v) < $signed(SAT_MIN))) begin
               wr_data = {1'b1, {(BW-1){1'b0}}};
               alu_ovf = ovf_q | opcode[8];
            end
         end
      endcase
   end

   assign p_ext    = AW'(mul_prod);
   assign p_signed = sign_q ? -p_ext : p_ext;
   assign wb_res   = addsub(accu_q, p_signed, sub_q);
   assign wb_accu  = mac_q ? wb_res[AW-1:0] : p_signed;
   assign wb_ovf   = mac_q & wb_res[AW];

   seq_multiplier #(.W(BW)) u_mult (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_mul),
      .a_i       (abs_a),
      .b_i       (abs_b),
      .last_o    (mul_last),
      .product_o (mul_prod)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         accu_q  <= '0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b1;
         sign_q  <= 1'b0;
         mac_q   <= 1'b0;
         sub_q   <= 1'b0;
         for (int i = 0; i < NR_LOCAL_REGS; i++) regs_q[i] <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (execute) begin
                  if (is_mul) begin
                     state_q <= MUL;
                     ready_q <= 1'b0;
                     sign_q  <= op_a[BW-1] ^ op_b[BW-1];
                     mac_q   <= opcode[4];
                     sub_q   <= opcode[0];
                  end else begin
                     accu_q <= alu_accu;
                     ovf_q  <= alu_ovf;
                     if (wr_en) regs_q[opcode[9 +: LW]] <= wr_data;
                  end
               end
            end
            MUL: if (mul_last) state_q <= WB;
            WB: begin
               accu_q  <= wb_accu;
               ovf_q   <= ovf_q | wb_ovf;
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready    = ready_q;
   assign accu     = accu_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_core_mac.sv
// Scoreboard bench for core_mac: arithmetic reference model feeds an expectation queue, a negedge monitor checks.
module tb_core_mac;

   localparam int BW = 8, NL = 8, NG = 9, AW = 20, CID = 5;

   logic              clk = 1'b0;
   logic              rst, execute;
   logic [15:0]       opcode;
   logic [NG*BW-1:0]  glob;
   logic              ready, overflow;
   logic [AW-1:0]     accu;

   always #5 clk = ~clk;

   core_mac #(.CORE_ID(CID), .BIT_WIDTH(BW), .NR_LOCAL_REGS(NL), .NR_GLOBAL_REGS(NG),
              .ACC_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .execute(execute),
      .global_registers_in(glob), .ready(ready), .accu(accu), .overflow(overflow));

   typedef struct { bit is_mul; longint acc; bit ovf; } exp_t;
   exp_t   sb[$];
   int     n_checks = 0, n_pass = 0;

   longint m_acc;
   bit     m_ovf;
   longint m_reg[NL];
   longint m_glb[NG];

   function automatic longint wrapn(longint x, int n);
      longint m, y;
      m = longint'(1) << n;
      y = x & (m - 1);
      if (y >= (m >>> 1)) y = y - m;
      return y;
   endfunction

   function automatic longint rd(int idx);
      if (idx < NL) return m_reg[idx];
      if (idx == 15) return wrapn(CID, BW);
      if (idx >= 16 && idx < 16 + NG) return m_glb[idx-16];
      return 0;
   endfunction

   task automatic check(input string name, input longint got, input longint want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: actual %0d required %0d at %0t", name, got, want, $time);
   endtask

   function automatic void upd(longint r);
      longint w;
      w = wrapn(r, AW);
      if (w != r) m_ovf = 1;
      m_acc = w;
   endfunction

   // Reference: apply one opcode to the abstract state, queue the visible result.
   function automatic void model(logic [15:0] op);
      longint a, b, p, v;
      int dst, sh;
      bit mul;
      exp_t e;
      mul = 0;
      dst = int'(op[13:9]);
      a = rd(int'(op[13:9]));
      b = rd(int'(op[8:5]));
      case (op[15:14])
         2'b00: if (dst < NL) m_reg[dst] = wrapn(longint'(op[7:0]), 8);
         2'b01: begin
            if (!op[1]) begin
               if (op[2]) a = m_acc;
               if (op[3]) b = m_acc;
               upd(op[0] ? a - b : a + b);
            end else begin
               mul = 1;
               p = a * b;
               if (!op[4]) m_acc = wrapn(p, AW);
               else upd(op[0] ? m_acc - p : m_acc + p);
            end
         end
         2'b10: begin
            sh = int'(op[6:3]);
            case (op[2:0])
               3'd0: begin m_acc = 0; m_ovf = 0; end
               3'd1: upd(-m_acc);
               3'd2: m_acc = m_acc >>> sh;
               3'd3: m_acc = wrapn(m_acc * (longint'(1) << sh), AW);
               3'd4: upd(m_acc < 0 ? -m_acc : m_acc);
               default: ;
            endcase
         end
         default: begin
            if (op[8]) begin
               v = m_acc >>> int'(op[7:4]);
               if (op[3] && v > 127) begin v = 127; m_ovf = 1; end
               else if (op[3] && v < -128) begin v = -128; m_ovf = 1; end
               else v = wrapn(v, BW);
               if (dst < NL) m_reg[dst] = v;
            end
         end
      endcase
      e.is_mul = mul; e.acc = m_acc; e.ovf = m_ovf;
      sb.push_back(e);
   endfunction

   function automatic void model_reset();
      m_acc = 0; m_ovf = 0;
      for (int i = 0; i < NL; i++) m_reg[i] = 0;
   endfunction

   task automatic set_glob(input int g, input longint v);
      m_glb[g] = wrapn(v, BW);
      glob[g*BW +: BW] = v[BW-1:0];
   endtask

   function automatic logic [15:0] op_load(input logic [4:0] d, input logic [7:0] imm);
      return {2'b00, d, 1'b0, imm};
   endfunction
   function automatic logic [15:0] op_alu(input logic [4:0] a, input logic [3:0] b, input logic [4:0] f);
      return {2'b01, a, b, f};
   endfunction
   function automatic logic [15:0] op_un(input logic [2:0] c, input logic [3:0] sh);
      return {2'b10, 7'd0, sh, c};
   endfunction
   function automatic logic [15:0] op_st(input logic [4:0] d, input logic [3:0] sh, input logic sat);
      return {2'b11, d, 1'b1, sh, sat, 3'b000};
   endfunction

   task automatic wait_ready();
      int g = 0;
      while (ready !== 1'b1 && g < 60) begin @(posedge clk); #1; g++; end
      if (ready !== 1'b1) begin
         n_checks++;
         $display("FAIL wait_ready: actual ready=%b required 1", ready);
      end
   endtask

   task automatic issue(input logic [15:0] op);
      wait_ready();
      model(op);
      opcode = op; execute = 1'b1;
      @(posedge clk); #1;
      execute = 1'b0;
   endtask

   // Monitor: an op is accepted at the edge after a negedge with execute & ready & !rst.
   bit   single_wait = 0, mul_wait = 0, rst_chk = 0;
   int   low_cnt;
   exp_t cur;

   always @(negedge clk) begin
      if (rst_chk) begin
         check("rst_accu", longint'($signed(accu)), 0);
         check("rst_ovf", longint'(overflow), 0);
         check("rst_ready", longint'(ready), 1);
         rst_chk = 0;
      end
      if (single_wait) begin
         check("op_accu", longint'($signed(accu)), cur.acc);
         check("op_ovf", longint'(overflow), longint'(cur.ovf));
         single_wait = 0;
      end
      if (mul_wait) begin
         if (ready !== 1'b1) begin
            low_cnt++;
            if (low_cnt > 3*BW) begin
               n_checks++;
               $display("FAIL mul_timeout: ready low for %0d cycles, required %0d", low_cnt, BW+1);
               mul_wait = 0;
            end
         end else begin
            check("mul_busy_cycles", low_cnt, BW+1);
            check("mul_accu", longint'($signed(accu)), cur.acc);
            check("mul_ovf", longint'(overflow), longint'(cur.ovf));
            mul_wait = 0;
         end
      end
      if (rst === 1'b1) begin
         mul_wait = 0;
         rst_chk  = 1;
      end else if (execute === 1'b1 && ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_accept: actual opcode=%h accepted, required none", opcode);
         end else begin
            cur = sb.pop_front();
            if (cur.is_mul) begin mul_wait = 1; low_cnt = 0; end
            else single_wait = 1;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] op;
      rst = 1'b1; execute = 1'b0; opcode = '0; glob = '0;
      model_reset();
      for (int g = 0; g < NG; g++) set_glob(g, longint'($urandom_range(0, 255)));
      set_glob(2, 64);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_accu", longint'($signed(accu)), 0);
      check("reset_ready", longint'(ready), 1);

      // 1: 5 * -3
      issue(op_load(5'd1, 8'h05));
      issue(op_load(5'd2, 8'hFD));
      issue(op_alu(5'd1, 4'd2, 5'b00010));
      wait_ready();
      check("t1_accu_const", longint'(accu), longint'(20'hFFFF1));
      // 2: MAC add then sub
      issue(op_alu(5'd1, 4'd1, 5'b10010));
      wait_ready();
      check("t2_mac_add_const", longint'($signed(accu)), 10);
      issue(op_alu(5'd1, 4'd1, 5'b10011));
      wait_ready();
      check("t2_mac_sub_const", longint'($signed(accu)), -15);
      // 3: accu=300, saturating store, read back, clear
      issue(op_load(5'd6, 8'h64));
      issue(op_alu(5'd6, 4'd6, 5'b00000));
      issue(op_alu(5'd0, 4'd6, 5'b00100));
      issue(op_st(5'd3, 4'd0, 1'b1));
      check("t3_sat_ovf_const", longint'(overflow), 1);
      issue(op_alu(5'd3, 4'd14, 5'b00000));
      check("t3_r3_const", longint'($signed(accu)), 127);
      issue(op_un(3'd0, 4'd0));
      // 4: load held during a multiply is taken only once ready returns
      issue(op_load(5'd4, 8'h22));
      issue(op_alu(5'd1, 4'd2, 5'b00010));
      op = op_load(5'd4, 8'h11);
      model(op);
      opcode = op; execute = 1'b1;
      wait_ready();
      @(posedge clk); #1 execute = 1'b0;
      issue(op_alu(5'd4, 4'd14, 5'b00000));
      // clear held while a MAC is busy must be ignored
      issue(op_alu(5'd1, 4'd1, 5'b10010));
      opcode = op_un(3'd0, 4'd0); execute = 1'b1;
      repeat (BW-1) begin @(posedge clk); #1; end
      execute = 1'b0;
      // 5: CORE_ID, global, unmapped indices
      issue(op_alu(5'd15, 4'd14, 5'b00000));
      issue(op_alu(5'd18, 4'd14, 5'b00000));
      check("t5_global_const", longint'(accu), 64);
      issue(op_alu(5'd30, 4'd14, 5'b00000));
      issue(op_alu(5'd25, 4'd15, 5'b00000));
      // 6: reset during a multiply, with a simultaneous execute
      issue(op_alu(5'd1, 4'd14, 5'b00000));
      issue(op_alu(5'd1, 4'd2, 5'b00010));
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1; execute = 1'b1; opcode = op_load(5'd1, 8'h33);
      @(posedge clk); #1;
      rst = 1'b0; execute = 1'b0;
      model_reset();
      repeat (15) begin @(posedge clk); #1; end
      issue(op_un(3'd2, 4'd0));
      issue(op_alu(5'd1, 4'd14, 5'b00000));

      // Randomized phase
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) == 0)
            set_glob(int'($urandom_range(0, NG-1)), longint'($urandom_range(0, 255)));
         op = 16'($urandom_range(0, 65535));
         issue(op);
         if (op[15:14] == 2'b01 && op[1])
            for (int g = 0; g < NG; g++) set_glob(g, longint'($urandom_range(0, 255)));
      end

      wait_ready();
      repeat (4) begin @(posedge clk); #1; end
      check("sb_drain", longint'(sb.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/core_mac.md
# core_mac

Parametrised successor of the GPU shader core. Executes one 16-bit opcode per accepted `execute` against a local register file, a broadcast global register bank and a wide signed accumulator. Adds the following to the previous core:
- signed multiply and multiply-accumulate, performed iteratively with a ready/busy handshake;
- unary accumulator operations;
- saturating, shifted stores;
- a sticky overflow flag.

One instance is placed per core slot under the GPU top, and all instances share opcode, `execute` and global registers.

## Interface
Parameters:
- `CORE_ID`, 0: value read at register index 15.
- `BIT_WIDTH`, 8: register width; must be ≥ 8.
- `NR_LOCAL_REGS`, 8: local registers; must be ≤ 14.
- `NR_GLOBAL_REGS`, 9: global registers; must be ≤ 16.
- `ACC_WIDTH`, 2*BIT_WIDTH+4: accumulator width, giving guard bits for MAC.

Ports:
- `clk` in 1: the only clock; all logic on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `opcode` in 16: instruction.
- `execute` in 1: issue strobe.
- `global_registers_in` in NR_GLOBAL_REGS*BIT_WIDTH: global register g occupies bits [g*BIT_WIDTH +: BIT_WIDTH].
- `ready` out 1: core can accept an opcode.
- `accu` out ACC_WIDTH: accumulator.
- `overflow` out 1: sticky signed-overflow flag.

## Operation
Register read map (5-bit index):
- 0..NR_LOCAL_REGS-1: local registers.
- 14: zero.
- 15: CORE_ID.
- 16..16+NR_GLOBAL_REGS-1: global registers.
- Every other index reads 0.
- Operand A index is `opcode[13:9]`. Operand B index is `{0,opcode[8:5]}`.
- Operands are signed and sign-extended to ACC_WIDTH.

Opcode classes, selected by `opcode[15:14]`:
- **00 load:** local register[13:9] ← `opcode[7:0]` sign-extended to BIT_WIDTH. A destination ≥ NR_LOCAL_REGS is a no-op.
- **01 two-operand:**
  - `[2]`/`[3]` replace operand A/B with `accu`.
  - `[0]` selects subtract.
  - `[1]=0`: accu ← A ± B, one cycle.
  - `[1]=1`: multiply. `[4]=0`: accu ← A*B. `[4]=1`: accu ← accu ± A*B, with `[0]` selecting the sign.
  - For a multiply, the operands are the BIT_WIDTH register values; `[2]`/`[3]` are ignored.
- **10 unary on accu**, selected by `[2:0]`:
  - 000: clear accu and `overflow`.
  - 001: negate.
  - 010: arithmetic shift right by `[6:3]`.
  - 011: shift left by `[6:3]`.
  - 100: absolute value.
  - All other codes are no-ops.
- **11 store**, active when `[8]=1`: v = accu >>> `[7:4]` (arithmetic).
  - `[3]=1`: saturate v to the signed BIT_WIDTH range, [-2^(BW-1), 2^(BW-1)-1]. If clamping occurs, set `overflow`.
  - `[3]=0`: truncate v to BIT_WIDTH bits.
  - Write the result to local register[13:9] under the same destination rule as load.

Arithmetic rules:
- All accu arithmetic is ACC_WIDTH two's complement and wraps.
- Signed overflow on add, sub, MAC, negate or abs sets `overflow`. Shift-left overflow does not.
- Negating the most-negative value gives the most-negative value and sets `overflow`.

Multiplier FSM:
- **IDLE:** `ready`=1. On an accepted multiply, latch |A|, |B|, the result sign, the MAC flag and the subtract flag, then go to MUL.
- **MUL:** radix-2 shift-add, one bit per cycle, for BIT_WIDTH cycles. A counter runs from BIT_WIDTH-1 down to 0. When the counter reaches 0, go to WB.
- **WB:** apply the sign, update accu (plain write or MAC), then return to IDLE.

## Timing
- Issue is accepted on an edge where `execute`=1 and `ready`=1.
- `execute` while `ready`=0 is ignored, not queued.
- Load, add/sub, unary and store take effect on the accepting edge. `ready` stays 1.
- Multiply accepted at edge N:
  - `ready`=0 after edges N through N+BIT_WIDTH.
  - accu is updated at edge N+BIT_WIDTH+1, and `ready`=1 after that same edge.
  - A back-to-back issue is possible on the cycle `ready` returns.
- Operands are latched at acceptance. Later register or global changes do not affect an in-flight multiply.
- Reset values, including on reset mid-multiply: accu=0, `overflow`=0, `ready`=1, FSM=IDLE, all local registers=0. A reset mid-multiply aborts the multiply and does not write back.
- Reset has priority over `execute` on the same edge.

## Structure
- **Package `core_mac_pkg`:**
  - opcode class constants;
  - unary op codes;
  - register index constants: REG_ZERO=14, REG_CORE_ID=15, REG_GLOBAL_BASE=16;
  - FSM state enum: IDLE, MUL, WB.
- **Sub-module `seq_multiplier`:** unsigned BIT_WIDTH×BIT_WIDTH shift-add multiplier with start/done. The core wraps it with sign handling and MAC logic.

## Test plan
BIT_WIDTH=8, ACC_WIDTH=20 for all scenarios.
1. Load r1=0x05, r2=0xFD, then issue mul r1*r2 → `ready` low for 9 cycles, then accu=0xFFFF1 (-15), `overflow`=0.
2. With accu=-15, issue MAC r1*r1 (add) → accu=10. Then issue MAC r1*r1 (sub) → accu=-15.
3. Unary set: accu=300, then store to r3 with saturation and shift 0 → r3=0x7F, `overflow`=1. Clear → accu=0, `overflow`=0.
4. Hold `execute` high with a load to r4=0x11 during a multiply → r4 unchanged. After `ready` rises, the same opcode loads 0x11.
5. Index 15 → CORE_ID. Global g2=0x40 at index 18 with add with zero → accu=0x00040. Index 30 reads 0.
6. Assert `rst` at cycle 4 of a multiply → after the edge, accu=0, `ready`=1, and no writeback occurs later.
